// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared FSM state codes, op codes, alu control codes and default width for muldiv_sequencer
package muldiv_pkg;
    localparam int XLEN_DEF = 32;
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_NEG_A   = 3'd1;
    localparam logic [2:0] S_NEG_B   = 3'd2;
    localparam logic [2:0] S_RUN     = 3'd3;
    localparam logic [2:0] S_NEG_OUT = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULHU  = 3'b001;
    localparam logic [2:0] OP_DIVU   = 3'b010;
    localparam logic [2:0] OP_REMU   = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b110;
    localparam logic [2:0] OP_REM    = 3'b111;
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
endpackage

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: handshake bus; master drives start/flush/op/a/b, slave drives busy/done/result
interface muldiv_sequencer_if import muldiv_pkg::*; #(parameter int XLEN = XLEN_DEF);
    logic            start;
    logic            flush;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    modport master(output start, flush, op, a, b, input busy, done, result);
    modport slave(input start, flush, op, a, b, output busy, done, result);
endinterface

// File: rtl/alu.sv
// alu: n-bit add/sub/and/or/slt unit (a, b, ALUControl in; Result, Carry, Negative, Zero, OverFlow out)
module alu #(parameter int n = 32) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic [2:0]   ALUControl,
    output logic [n-1:0] Result,
    output logic         Carry,
    output logic         Negative,
    output logic         Zero,
    output logic         OverFlow
);
    logic [n-1:0] bb;
    logic [n-1:0] sum;
    logic         cout;
    always_comb begin
        bb = ALUControl[0] ? ~b : b;
        {cout, sum} = {1'b0, a} + {1'b0, bb} + {{n{1'b0}}, ALUControl[0]};
        OverFlow = ~ALUControl[1] & (a[n-1] ^ sum[n-1]) & ~(a[n-1] ^ b[n-1] ^ ALUControl[0]);
        Result = ALUControl[2] ? {{(n-1){1'b0}}, sum[n-1] ^ OverFlow} :
                 ALUControl[1] ? (ALUControl[0] ? (a | b) : (a & b)) : sum;
        Carry = ~ALUControl[1] & cout;
        Negative = Result[n-1];
        Zero = ~|Result;
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative shift-add MUL/MULHU and restoring DIVU/REMU over one alu (clk, rst, bus slave); MULDIV_SIGNED_EN adds signed DIV/REM
module muldiv_sequencer import muldiv_pkg::*; #(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = 6
) (
    input  logic clk,
    input  logic rst,
    muldiv_sequencer_if.slave bus
);
    logic [2:0]       state;
`ifdef MULDIV_SIGNED_EN
    logic [2:0]       op_r;
    logic             sign_q;
`else
    logic [1:0]       op_r;
`endif
    logic [XLEN-1:0]  a_r, b_r, hi, lo, res_r;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  alu_a, alu_b, sum, shifted, sel;
    logic [2:0]       alu_ctl, start_next, run_exit;
    logic             carry, take, is_div, dz;
    logic             neg_unused, zero_unused, ovf_unused;

    alu #(.n(XLEN)) u_alu (
        .a(alu_a), .b(alu_b), .ALUControl(alu_ctl), .Result(sum),
        .Carry(carry), .Negative(neg_unused), .Zero(zero_unused), .OverFlow(ovf_unused)
    );

    always_comb begin
        is_div = op_r[1];
        shifted = {hi[XLEN-2:0], lo[XLEN-1]};
        take = carry | hi[XLEN-1];
        sel = op_r[0] ? hi : lo;
        dz = bus.op[1] && bus.b == '0;
        alu_a = '0;
        alu_b = '0;
        alu_ctl = ALU_ADD;
`ifdef MULDIV_SIGNED_EN
        start_next = dz ? S_DONE : (bus.op[2] & bus.op[1]) ? S_NEG_A : S_RUN;
        run_exit = (op_r[2] & op_r[1]) ? S_NEG_OUT : S_DONE;
`else
        start_next = dz ? S_DONE : S_RUN;
        run_exit = S_DONE;
`endif
        if (state == S_RUN) begin
            alu_a = is_div ? shifted : hi;
            alu_b = is_div ? b_r : (lo[0] ? a_r : '0);
            alu_ctl = is_div ? ALU_SUB : ALU_ADD;
        end
`ifdef MULDIV_SIGNED_EN
        else if (state == S_NEG_A || state == S_NEG_B || state == S_NEG_OUT) begin
            alu_b = state == S_NEG_A ? lo : state == S_NEG_B ? b_r : sel;
            alu_ctl = ALU_SUB;
        end
`endif
    end

    assign bus.busy = state != S_IDLE && state != S_DONE;
    assign bus.done = state == S_DONE;
    assign bus.result = state == S_DONE ? sel : res_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            op_r <= '0;
            a_r <= '0;
            b_r <= '0;
            hi <= '0;
            lo <= '0;
            cnt <= '0;
            res_r <= '0;
`ifdef MULDIV_SIGNED_EN
            sign_q <= 1'b0;
`endif
        end else if (state == S_IDLE) begin
            if (bus.start && !bus.flush) begin
`ifdef MULDIV_SIGNED_EN
                op_r <= bus.op;
                sign_q <= bus.a[XLEN-1] ^ bus.b[XLEN-1];
`else
                op_r <= bus.op[1:0];
`endif
                a_r <= bus.a;
                b_r <= bus.b;
                cnt <= '0;
                hi <= dz ? bus.a : '0;
                lo <= bus.op[1] ? (dz ? '1 : bus.a) : bus.b;
                state <= start_next;
            end
        end else if (state == S_DONE) begin
            res_r <= sel;
            state <= S_IDLE;
        end else if (bus.flush) begin
            state <= S_IDLE;
        end else if (state == S_RUN) begin
            hi <= is_div ? (take ? sum : shifted) : {carry, sum[XLEN-1:1]};
            lo <= is_div ? {lo[XLEN-2:0], take} : {sum[0], lo[XLEN-1:1]};
            cnt <= cnt + 1'b1;
            state <= cnt == CNT_W'(XLEN - 1) ? run_exit : S_RUN;
        end
`ifdef MULDIV_SIGNED_EN
        else if (state == S_NEG_A) begin
            lo <= a_r[XLEN-1] ? sum : lo;
            state <= S_NEG_B;
        end else if (state == S_NEG_B) begin
            b_r <= b_r[XLEN-1] ? sum : b_r;
            state <= S_RUN;
        end else if (state == S_NEG_OUT) begin
            hi <= (op_r[0] && a_r[XLEN-1]) ? sum : hi;
            lo <= (!op_r[0] && sign_q) ? sum : lo;
            state <= S_DONE;
        end
`endif
        else begin
            state <= S_IDLE;
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: scoreboard bench for muldiv_sequencer covering reset, mul/div, divide by zero, flush, busy-start, mid-run reset, signed ops
module tb_muldiv_sequencer;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;
    logic [31:0] last_res;
    logic [31:0] sb_q[$];
    int lat_q[$];

    muldiv_sequencer_if #(.XLEN(32)) bus();
    muldiv_sequencer #(.XLEN(32), .CNT_W(6)) dut(.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        case (op[1:0])
            2'b00: return p[31:0];
            2'b01: return p[63:32];
            2'b10: return b == 0 ? 32'hFFFF_FFFF : a / b;
            default: return b == 0 ? a : a % b;
        endcase
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp, input int lat_exp);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        sb_q.push_back(exp);
        lat_q.push_back(lat_exp);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic collect(input string name, input int lat0);
        int lat;
        logic [31:0] e;
        int el;
        lat = lat0;
        while (!bus.done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = sb_q.pop_front();
        el = lat_q.pop_front();
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: done=%b after %0d cycles, required 1", name, bus.done, lat);
        end else begin
            checks += 3;
            if (bus.result !== e) begin
                errors++;
                $display("FAIL %s result: got %h required %h", name, bus.result, e);
            end
            if (lat != el) begin
                errors++;
                $display("FAIL %s latency: got %0d required %0d", name, lat, el);
            end
            if (bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_in_done: got %b required 0", name, bus.busy);
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.done !== 1'b0 || bus.result !== e) begin
                errors++;
                $display("FAIL %s hold: done=%b result=%h required done=0 result=%h", name, bus.done, bus.result, e);
            end
            last_res = e;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b result=%h required 0 0 0", bus.busy, bus.done, bus.result);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_mul;
        issue(3'b000, 32'd7, 32'd6, 32'd42, 33);
        collect("mul_7x6", 1);
        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        collect("mulhu_max", 1);
    endtask

    task automatic test_div;
        issue(3'b010, 32'd100, 32'd7, 32'd14, 33);
        collect("divu_100_7", 1);
        issue(3'b011, 32'd100, 32'd7, 32'd2, 33);
        collect("remu_100_7", 1);
        issue(3'b010, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
        collect("divu_max_1", 1);
    endtask

    task automatic test_div_zero;
        issue(3'b010, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        collect("divu_by_zero", 1);
        issue(3'b011, 32'd5, 32'd0, 32'd5, 1);
        collect("remu_by_zero", 1);
    endtask

    task automatic test_flush;
        logic seen;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = 3'b010;
        bus.a = 32'd100;
        bus.b = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== last_res) begin
            errors++;
            $display("FAIL flush: busy=%b done=%b result=%h required 0 0 %h", bus.busy, bus.done, bus.result, last_res);
        end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            seen = seen | bus.done;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_done: done seen=%b required 0", seen);
        end
        @(negedge clk);
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op = 3'b010;
        bus.b = 32'd0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL flush_with_start: busy=%b done=%b required 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_start_busy;
        logic seen;
        issue(3'b000, 32'd3, 32'd5, 32'd15, 33);
        repeat (3) begin
            @(negedge clk);
            bus.start = 1'b1;
            bus.op = 3'b010;
            bus.a = 32'd100;
            bus.b = 32'd0;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        collect("start_during_busy", 4);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            seen = seen | bus.done;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL start_busy_extra_done: done seen=%b required 0", seen);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = 3'b000;
        bus.a = 32'd9;
        bus.b = 32'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_run: busy=%b done=%b result=%h required 0 0 0", bus.busy, bus.done, bus.result);
        end
        @(negedge clk);
        rst = 1'b0;
        issue(3'b000, 32'd12, 32'd12, 32'd144, 33);
        collect("after_reset_mul", 1);
    endtask

    task automatic test_op_alias;
        issue(3'b100, 32'd7, 32'd6, 32'd42, 33);
        collect("op100_as_mul", 1);
        issue(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        collect("op101_as_mulhu", 1);
    endtask

    task automatic test_signed;
`ifdef MULDIV_SIGNED_EN
        issue(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 36);
        collect("div_m7_2", 1);
        issue(3'b111, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 36);
        collect("rem_m7_2", 1);
        issue(3'b110, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 36);
        collect("div_7_m2", 1);
        issue(3'b111, 32'd7, 32'hFFFF_FFFE, 32'd1, 36);
        collect("rem_7_m2", 1);
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 36);
        collect("div_min_m1", 1);
        issue(3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 36);
        collect("rem_min_m1", 1);
        issue(3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1);
        collect("div_by_zero", 1);
        issue(3'b111, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1);
        collect("rem_by_zero", 1);
`else
        issue(3'b110, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33);
        collect("op110_as_divu", 1);
        issue(3'b111, 32'hFFFF_FFF9, 32'd2, 32'd1, 33);
        collect("op111_as_remu", 1);
`endif
    endtask

    task automatic test_back_to_back;
        logic [2:0] op;
        logic [31:0] a, b;
        for (int i = 0; i < 8; i++) begin
            op = 3'(i % 4);
            a = $urandom;
            b = (i % 3 == 0) ? $urandom : 32'($urandom_range(1, 1000));
            issue(op, a, b, model(op, a, b), (op[1] && b == 0) ? 1 : 33);
            collect("random_op", 1);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op = 3'b000;
        bus.a = 32'h0;
        bus.b = 32'h0;
        rst = 1'b1;
        last_res = 32'h0;
        test_reset;
        test_mul;
        test_div;
        test_div_zero;
        test_flush;
        test_start_busy;
        test_reset_mid;
        test_op_alias;
        test_signed;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
